reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer. Allocates a tag for each issued instruction and collects results from the common data bus (CDB).
- Retires entries in program order and drives the commit interface (rob_en/rob_dest/rob_tag) consumed by prod_table.
- Serves operand lookups for the dispatch stage.
- Sits between dispatch/issue, the execution units' CDB, and the register producer table / register file.

Parameters:
TAG_W, 3, tag width; this is the same quantity as `ROB_SIZE in the codebase; DEPTH = 2**TAG_W entries
REG_W, 5, destination register address width (`REG_ADDR_WIDTH)
DATA_W, 32, result data width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
stall_i  in  1  pipeline stall; blocks allocation only
flush_i  in  1  synchronous flush of all entries
issue_en  in  1  dispatch requests one allocation
issue_rd_addr  in  REG_W  destination register of the issuing instruction
issue_tag  out  TAG_W  tag granted to the issuing instruction (equals tail index)
issue_ack  out  1  allocation accepted this cycle
rob_full  out  1  all DEPTH entries valid
rob_empty  out  1  no valid entries
cdb_en  in  1  result broadcast valid
cdb_tag  in  TAG_W  tag of the broadcast result
cdb_data  in  DATA_W  broadcast result
q1_tag, q2_tag  in  TAG_W  operand lookup tags
q1_ready, q2_ready  out  1  looked-up entry holds its result
q1_data, q2_data  out  DATA_W  looked-up result (0 when not ready)
rob_en  out  1  commit strobe
rob_dest  out  REG_W  committed destination register
rob_tag  out  TAG_W  committed tag
rob_data  out  DATA_W  committed result

Behaviour:
- State:
  - head_ptr and tail_ptr, each TAG_W+1 bits; the extra MSB is a wrap bit.
  - Per entry: valid, done, dest[REG_W], data[DATA_W].
- Status flags:
  - rob_empty = (head_ptr == tail_ptr).
  - rob_full = low bits equal and MSBs differ.
- Reset (rst=1 at posedge):
  - Pointers = 0; all valid/done = 0; data = 0.
  - Outputs after reset: rob_en=0, rob_dest=0, rob_tag=0, rob_data=0, issue_ack=0, issue_tag=0, rob_empty=1, rob_full=0, q*_ready=0, q*_data=0.
  - A reset asserted mid-operation discards all entries identically.
- Flush (flush_i=1, rst=0):
  - Same clearing as reset.
  - Has priority over issue, CDB and commit in that cycle.
  - issue_ack=0 and rob_en=0 combinationally while flush_i=1.
- Allocation:
  - issue_ack = issue_en & ~stall_i & ~rob_full & ~flush_i (combinational).
  - issue_tag = tail_ptr[TAG_W-1:0] at all times.
  - On ack: entry[tail] gets valid=1, done=0, dest=issue_rd_addr; tail_ptr increments, wrapping naturally.
  - rob_full is evaluated on current-cycle state. A commit in the same cycle does NOT make room; the issue is refused and dispatch retries.
- Writeback:
  - On cdb_en with entry[cdb_tag].valid=1: data is written and done=1 at the edge.
  - cdb_en to an invalid entry is ignored.
  - A repeated broadcast overwrites data.
- Commit, one per cycle, independent of stall_i:
  - rob_en = entry[head].valid & entry[head].done & ~flush_i (combinational).
  - rob_dest/rob_tag/rob_data reflect the head entry while rob_en=1 and are 0 otherwise.
  - On rob_en: entry[head].valid=0, done=0, and head_ptr increments.
  - A CDB write to the head entry commits no earlier than the following cycle (one-cycle minimum writeback-to-commit latency).
  - Entries with dest=0 allocate and commit normally; consumers ignore x0.
- Simultaneous events:
  - Issue and commit in the same cycle both take effect.
  - A CDB write and an allocation can never target the same index, because the tail entry is invalid.
- Operand lookup (combinational):
  - qN_ready = entry[qN_tag].valid & (entry.done | (cdb_en & cdb_tag==qN_tag)).
  - Data is taken from cdb_data on the same-cycle bypass, otherwise from the entry.
  - For an invalid entry, ready=0 and data=0.

Test Plan:
- Reset then issue rd=10, rd=5, rd=3 on consecutive cycles -> issue_tag 0,1,2 with issue_ack=1 each; rob_empty drops to 0 after the first edge; no rob_en.
- CDB tag1 data 0xBB, then tag0 data 0xAA -> no commit until tag0 is done. Then rob_en on consecutive cycles: (dest=10, tag=0, data=0xAA), then (dest=5, tag=1, data=0xBB). Tag2 does not commit.
- Fill 8 entries with no writeback -> rob_full=1 and 9th issue_ack=0. Complete tag0, then retry issue while committing -> issue refused that cycle, accepted next cycle with issue_tag=0 (wrap).
- q1_tag=2 with CDB tag2 data 0x55 in the same cycle -> q1_ready=1, q1_data=0x55. Next cycle the same response comes from storage.
- stall_i=1 with issue_en=1 and a completed head -> issue_ack=0, but rob_en=1 and commit proceeds.
- flush_i asserted with 4 valid entries and a completed head -> rob_en=0 that cycle; the next cycle shows rob_empty=1 and issue_tag=0. Repeat using rst mid-operation -> identical result.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at dispatch, captures CDB
// results, retires in program order and answers dispatch operand lookups.
module reorder_buffer #(
  parameter int TAG_W  = 3,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              issue_en,
  input  logic [REG_W-1:0]  issue_rd_addr,
  output logic [TAG_W-1:0]  issue_tag,
  output logic              issue_ack,
  output logic              rob_full,
  output logic              rob_empty,
  input  logic              cdb_en,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              rob_en,
  output logic [REG_W-1:0]  rob_dest,
  output logic [TAG_W-1:0]  rob_tag,
  output logic [DATA_W-1:0] rob_data
);

  localparam int DEPTH = 2 ** TAG_W;

  logic [TAG_W:0]      head_ptr, tail_ptr;
  logic [DEPTH-1:0]    valid_q, done_q;
  logic [REG_W-1:0]    dest_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];

  logic [TAG_W-1:0]    head_idx, tail_idx;
  logic                q1_bypass, q2_bypass;

  assign head_idx = head_ptr[TAG_W-1:0];
  assign tail_idx = tail_ptr[TAG_W-1:0];

  always_comb begin
    rob_empty = (head_ptr == tail_ptr);
    rob_full  = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);
    issue_tag = tail_idx;
    issue_ack = issue_en & ~stall_i & ~rob_full & ~flush_i;
  end

  // Commit reads registered done, so a CDB write to head retires a cycle later.
  always_comb begin
    rob_en   = valid_q[head_idx] & done_q[head_idx] & ~flush_i;
    rob_dest = '0;
    rob_tag  = '0;
    rob_data = '0;
    if (rob_en) begin
      rob_dest = dest_q[head_idx];
      rob_tag  = head_idx;
      rob_data = data_q[head_idx];
    end
  end

  always_comb begin
    q1_bypass = cdb_en && (cdb_tag == q1_tag);
    q2_bypass = cdb_en && (cdb_tag == q2_tag);
    q1_ready  = valid_q[q1_tag] & (done_q[q1_tag] | q1_bypass);
    q2_ready  = valid_q[q2_tag] & (done_q[q2_tag] | q2_bypass);
    q1_data   = '0;
    q2_data   = '0;
    if (q1_ready) q1_data = q1_bypass ? cdb_data : data_q[q1_tag];
    if (q2_ready) q2_data = q2_bypass ? cdb_data : data_q[q2_tag];
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      valid_q  <= '0;
      done_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (issue_ack) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        dest_q[tail_idx]  <= issue_rd_addr;
        tail_ptr          <= tail_ptr + 1'b1;
      end
      if (cdb_en && valid_q[cdb_tag]) begin
        data_q[cdb_tag] <= cdb_data;
        done_q[cdb_tag] <= 1'b1;
      end
      // Placed after the CDB write so a late rebroadcast cannot revive a retiring entry.
      if (rob_en) begin
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head_ptr          <= head_ptr + 1'b1;
      end
    end
  end

endmodule
